// File: rtl/multibyte_addsub_seq_if.sv
// rtl/multibyte_addsub_seq_if.sv - start/done request bus for the byte-serial add/sub sequencer
// ADDSUB_FLAGS_EN adds the zero and cout result flags.
interface multibyte_addsub_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         ovr;
`ifdef ADDSUB_FLAGS_EN
    logic         zero;
    logic         cout;
`endif

    modport master (
        output start, m, a, b,
        input  busy, done, s, ovr
`ifdef ADDSUB_FLAGS_EN
        , input zero, cout
`endif
    );

    modport slave (
        input  start, m, a, b,
        output busy, done, s, ovr
`ifdef ADDSUB_FLAGS_EN
        , output zero, cout
`endif
    );
endinterface

// File: rtl/multibyte_addsub_seq.sv
// rtl/multibyte_addsub_seq.sv - NBYTES-wide add/sub built from one 8-bit slice, LSB byte first
// ADDSUB_FLAGS_EN adds registered zero and cout result flags.
module multibyte_addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multibyte_addsub_seq_if.slave  bus
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              m_q, m_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      s_q, s_d;
    logic              ovr_q, ovr_d;
`ifdef ADDSUB_FLAGS_EN
    logic              zero_q, zero_d;
    logic              cout_q, cout_d;
`endif

    logic [7:0] a_byte;
    logic [7:0] bx_byte;
    logic [8:0] sum9;
    logic [7:0] low8;
    logic       last_byte;

    // low8[7] is the carry into bit 7 of the slice, needed for signed overflow
    always_comb begin
        a_byte    = a_q[{idx_q, 3'b000} +: 8];
        bx_byte   = b_q[{idx_q, 3'b000} +: 8] ^ {8{m_q}};
        sum9      = {1'b0, a_byte} + {1'b0, bx_byte} + {8'b0, carry_q};
        low8      = {1'b0, a_byte[6:0]} + {1'b0, bx_byte[6:0]} + {7'b0, carry_q};
        last_byte = (idx_q == IDXW'(NBYTES - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        ovr_d   = ovr_q;
`ifdef ADDSUB_FLAGS_EN
        zero_d  = zero_q;
        cout_d  = cout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = bus.m;
                    idx_d   = '0;
                    carry_d = bus.m;
                end
            end
            RUN: begin
                acc_d[{idx_q, 3'b000} +: 8] = sum9[7:0];
                carry_d = sum9[8];
                if (last_byte) begin
                    s_d     = acc_d;
                    ovr_d   = low8[7] ^ sum9[8];
`ifdef ADDSUB_FLAGS_EN
                    zero_d  = (acc_d == '0);
                    cout_d  = sum9[8];
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            m_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            ovr_q   <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            ovr_q   <= ovr_d;
`ifdef ADDSUB_FLAGS_EN
            zero_q  <= zero_d;
            cout_q  <= cout_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.ovr  = ovr_q;
`ifdef ADDSUB_FLAGS_EN
    assign bus.zero = zero_q;
    assign bus.cout = cout_q;
`endif
endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// tb/tb_multibyte_addsub_seq.sv - directed and random checks of multibyte_addsub_seq against a W-bit arithmetic model
// ADDSUB_FLAGS_EN also checks the zero and cout flags.
module tb_multibyte_addsub_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multibyte_addsub_seq_if #(.NBYTES(NB)) bus ();
    multibyte_addsub_seq #(.NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [W-1:0] exp_s;
    logic         exp_ovr;
    logic         exp_zero;
    logic         exp_cout;
    logic [W-1:0] prev_s;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Whole-word reference: plain W-bit arithmetic and signed range test
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        longint sa, sb, r;
        logic [W:0] full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            full     = {1'b0, a} - {1'b0, b};
            r        = sa - sb;
            exp_cout = (a >= b);
        end else begin
            full     = {1'b0, a} + {1'b0, b};
            r        = sa + sb;
            exp_cout = full[W];
        end
        exp_s    = full[W-1:0];
        exp_ovr  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        exp_zero = (exp_s == '0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        model(a, b, m);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.m = m; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.m = ~m;
        for (int k = 0; k < NB; k++) begin
            chk("busy_run", W'(bus.busy), W'(1));
            chk("done_run", W'(bus.done), W'(0));
            if (k == 1) chk("s_hold_run", bus.s, prev_s);
            @(negedge clk);
        end
        chk("done_pulse", W'(bus.done), W'(1));
        chk("busy_done", W'(bus.busy), W'(0));
        chk("s_result", bus.s, exp_s);
        chk("ovr_result", W'(bus.ovr), W'(exp_ovr));
`ifdef ADDSUB_FLAGS_EN
        chk("zero_result", W'(bus.zero), W'(exp_zero));
        chk("cout_result", W'(bus.cout), W'(exp_cout));
`endif
        @(negedge clk);
        chk("done_single", W'(bus.done), W'(0));
        chk("s_hold_idle", bus.s, exp_s);
        prev_s = exp_s;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.m = 1'b0;
        prev_s = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_s", bus.s, '0);
        chk("rst_ovr", W'(bus.ovr), W'(0));
        rst = 1'b0;

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("carry_chain_s", bus.s, 32'h0000_0100);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1);

        // start held high: mid-RUN operand change is ignored, DONE restarts immediately
        @(negedge clk);
        bus.a = 32'h0101_0101; bus.b = 32'h0101_0101; bus.m = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.a = 32'h1111_1111;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("held_done1", W'(bus.done), W'(1));
        chk("held_s1", bus.s, 32'h0202_0202);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            chk("held_gap", W'(bus.done), W'(0));
        end
        @(negedge clk);
        chk("held_done2", W'(bus.done), W'(1));
        chk("held_s2", bus.s, 32'h1212_1212);
        bus.start = 1'b0;
        prev_s = 32'h1212_1212;
        @(negedge clk);

        // reset on the second RUN cycle aborts the operation
        @(negedge clk);
        bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101; bus.m = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", W'(bus.busy), W'(0));
        chk("mid_rst_done", W'(bus.done), W'(0));
        chk("mid_rst_s", bus.s, '0);
        chk("mid_rst_ovr", W'(bus.ovr), W'(0));
        rst = 1'b0;
        prev_s = '0;
        for (int k = 0; k < NB + 2; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", W'(bus.done), W'(0));
        end
        do_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
